// File: rtl/uart_rx_pkg.sv
// Shared definitions for the serial receiver: default frame geometry and FSM state encoding.
package uart_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous input and give it a full cycle to settle before use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial frame receiver: start bit, LSB-first data, optional even parity, one stop bit.
// Each bit is sampled at its midpoint using a clock-count timer started from the start-bit edge.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        index;
  logic [DATA_BITS-1:0] shreg;
  logic                 pbad;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  // Delayed copy of the synchronised line so a high-to-low transition can be recognised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  // Frame FSM with bit timer, shift register and registered one-cycle result flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      index      <= '0;
      shreg      <= '0;
      pbad       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s && rx_prev) begin
            timer <= '0;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            if (!rx_s) begin
              index <= '0;
              pbad  <= 1'b0;
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == T_FULL) begin
            timer <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (index == I_LAST) begin
              index <= '0;
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              index <= index + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PARITY: begin
          if (timer == T_FULL) begin
            timer <= '0;
            pbad  <= (^shreg) ^ rx_s;
            state <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              parity_err <= pbad;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a parity-enabled receiver and a parity-less receiver on separate lines.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] data_out, data_out2;
  logic       dv, pe, fe, busy;
  logic       dv2, pe2, fe2, busy2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  int dv_cyc = 0, pe_cyc = 0, fe_cyc = 0;
  int busy_rises = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
  int dv2_cnt = 0, dv2_cyc = 0;
  logic busy_q = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out),
    .data_valid(dv), .parity_err(pe), .frame_err(fe), .busy(busy)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0)) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .data_out(data_out2),
    .data_valid(dv2), .parity_err(pe2), .frame_err(fe2), .busy(busy2)
  );

  // Free-running clock and a cycle counter used as the time base for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse and busy transition on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dv) begin dv_cnt++; dv_cyc = cyc; end
    if (pe) begin pe_cnt++; pe_cyc = cyc; end
    if (fe) begin fe_cnt++; fe_cyc = cyc; end
    if (busy && !busy_q) begin busy_rises++; busy_rise_cyc = cyc; end
    if (!busy && busy_q) busy_fall_cyc = cyc;
    busy_q = busy;
    if (dv2) begin dv2_cnt++; dv2_cyc = cyc; end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx2 = v;
    else rx = v;
  endtask

  // Drives one full frame starting at a falling clock edge; leaves the line at the stop-bit level.
  task automatic applyStimulus(input bit sel, input logic [7:0] d, input logic par,
                               input logic stp, input bit use_par, output int t0);
    drive(sel, 1'b0);
    t0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      repeat (CPB) @(negedge clk);
    end
    if (use_par) begin
      drive(sel, par);
      repeat (CPB) @(negedge clk);
    end
    drive(sel, stp);
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int t0, t1, c1, n, rises;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_data_valid", dv, 0);
    checkOutput("reset_parity_err", pe, 0);
    checkOutput("reset_frame_err", fe, 0);
    checkOutput("reset_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] good frame 0xA5");
    applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, t0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("a5_valid_count", dv_cnt, 1);
    checkOutput("a5_valid_latency", dv_cyc - t0, 171);
    checkOutput("a5_data", data_out, 8'hA5);
    checkOutput("a5_parity_err", pe_cnt, 0);
    checkOutput("a5_frame_err", fe_cnt, 0);
    checkOutput("a5_busy_rise", busy_rise_cyc - t0, 3);
    checkOutput("a5_busy_fall", busy_fall_cyc - t0, 171);
    checkOutput("a5_busy_idle", busy, 0);

    $display("[TB] bad parity frame 0x3C");
    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, t0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("3c_valid_count", dv_cnt, 2);
    checkOutput("3c_data", data_out, 8'h3C);
    checkOutput("3c_parity_count", pe_cnt, 1);
    checkOutput("3c_parity_with_valid", pe_cyc - dv_cyc, 0);
    checkOutput("3c_frame_err", fe_cnt, 0);

    $display("[TB] framing error 0x81, line held low");
    applyStimulus(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, t0);
    rises = busy_rises;
    checkOutput("81_frame_count", fe_cnt, 1);
    checkOutput("81_frame_latency", fe_cyc - t0, 171);
    checkOutput("81_valid_count", dv_cnt, 2);
    checkOutput("81_parity_count", pe_cnt, 1);
    checkOutput("81_data_held", data_out, 8'h3C);
    repeat (60) @(negedge clk);
    checkOutput("81_low_no_retrigger", busy_rises, rises);
    checkOutput("81_low_busy", busy, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] glitch then 0x55");
    rises = busy_rises;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("glitch_busy_rise", busy_rises, rises + 1);
    checkOutput("glitch_busy_idle", busy, 0);
    checkOutput("glitch_no_valid", dv_cnt, 2);
    checkOutput("glitch_no_frame_err", fe_cnt, 1);
    applyStimulus(1'b0, 8'h55, 1'b0, 1'b1, 1'b1, t0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("55_data", data_out, 8'h55);
    checkOutput("55_valid_latency", dv_cyc - t0, 171);
    checkOutput("55_valid_count", dv_cnt, 3);

    $display("[TB] back-to-back 0x00 then 0xFF");
    n = dv_cnt;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, t0);
    c1 = dv_cyc;
    checkOutput("b2b_first_latency", c1 - t0, 171);
    checkOutput("b2b_first_data", data_out, 8'h00);
    applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, t1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("b2b_spacing", dv_cyc - c1, 176);
    checkOutput("b2b_second_data", data_out, 8'hFF);
    checkOutput("b2b_valid_count", dv_cnt, n + 2);

    $display("[TB] reset during data bit 3 of 0xC3");
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = (8'hC3 >> i) & 1;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    checkOutput("c3_busy_before_reset", busy, 1);
    reset = 1'b0;
    #1;
    checkOutput("c3_reset_data_out", data_out, 0);
    checkOutput("c3_reset_busy", busy, 0);
    checkOutput("c3_reset_valid", dv, 0);
    checkOutput("c3_reset_frame_err", fe, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rises = busy_rises;
    n = dv_cnt;
    repeat (40) @(negedge clk);
    checkOutput("c3_no_resume", busy_rises, rises);
    checkOutput("c3_no_valid", dv_cnt, n);
    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, t0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("5a_data", data_out, 8'h5A);
    checkOutput("5a_valid_latency", dv_cyc - t0, 171);

    $display("[TB] parity-less receiver 0x5A");
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, t0);
    rx2 = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("np_valid_count", dv2_cnt, 1);
    checkOutput("np_valid_latency", dv2_cyc - t0, 155);
    checkOutput("np_data", data_out2, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
